sb_corner_param: RTL and testbench

SB_CORNER_PARAM -- requirements
Module: sb_corner_param

---
 rtl/sb_corner_param_if.sv | 29 ++
 rtl/sb_corner_param.sv | 128 ++++++++++++
 tb/tb_sb_corner_param.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_corner_param_if.sv
// Bus bundle for the corner switch block: configuration handshake plus channel and pad tracks.
// The master side drives programming and routing inputs; the slave side is the switch block.
interface sb_corner_param_if #(
  parameter int CHAN_WIDTH = 3,
  parameter int NUM_PADS   = 8
);
  logic                  prog_en;
  logic                  prog_commit;
  logic                  ccff_head;
  logic [CHAN_WIDTH-1:0] chany_top_in;
  logic [CHAN_WIDTH-1:0] chanx_right_in;
  logic [NUM_PADS-1:0]   pad_in;
  logic [CHAN_WIDTH-1:0] chany_top_out;
  logic [CHAN_WIDTH-1:0] chanx_right_out;
  logic                  ccff_tail;
  logic                  cfg_ready;
  logic                  cfg_active;
  logic                  cfg_err;

  modport master (
    output prog_en, prog_commit, ccff_head, chany_top_in, chanx_right_in, pad_in,
    input  chany_top_out, chanx_right_out, ccff_tail, cfg_ready, cfg_active, cfg_err
  );

  modport slave (
    input  prog_en, prog_commit, ccff_head, chany_top_in, chanx_right_in, pad_in,
    output chany_top_out, chanx_right_out, ccff_tail, cfg_ready, cfg_active, cfg_err
  );
endinterface

// File: rtl/sb_corner_param.sv
// Corner switch block with a shadow/active configuration chain and muxed right-channel tracks.
// Optional feature: define SB_CFG_PARITY_EN to append an even-parity bit to each frame.
module sb_corner_param #(
  parameter int CHAN_WIDTH = 3,
  parameter int NUM_PADS   = 8
) (
  input logic             prog_clk,
  input logic             prog_rst_n,
  sb_corner_param_if.slave bus
);
  localparam int SEL_W     = $clog2(1 + (NUM_PADS + CHAN_WIDTH - 1) / CHAN_WIDTH);
  localparam int CFG_BITS  = CHAN_WIDTH * SEL_W;
  localparam int NSEL      = 1 << SEL_W;
  localparam int PAD_EXT_W = (NSEL - 1) * CHAN_WIDTH;
`ifdef SB_CFG_PARITY_EN
  localparam int FRAME_LEN = CFG_BITS + 1;
`else
  localparam int FRAME_LEN = CFG_BITS;
`endif
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] S_UNCFG   = 2'd0;
  localparam logic [1:0] S_LOADING = 2'd1;
  localparam logic [1:0] S_LOADED  = 2'd2;
  localparam logic [1:0] S_ACTIVE  = 2'd3;

  logic [1:0]           r_state;
  logic [FRAME_LEN-1:0] r_shadow;
  logic [CFG_BITS-1:0]  r_active;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_cfg_active;
  logic                 r_cfg_err;

  logic                  w_in_loaded;
  logic                  w_parity_ok;
  logic                  w_commit_ok;
  logic                  w_commit_bad;
  logic                  w_do_shift;
  logic                  w_frame_start;
  logic                  w_last_shift;
  logic [CFG_BITS-1:0]   w_shadow_cfg;
  logic [PAD_EXT_W-1:0]  w_pad_ext;
  logic [CHAN_WIDTH-1:0] w_right_out;
  logic [NSEL-1:0]       w_cand [CHAN_WIDTH];
  logic [SEL_W-1:0]      w_sel  [CHAN_WIDTH];

  // Routing bits sit at the top of the shadow; a parity bit, if present, is the LSB.
  assign w_shadow_cfg = r_shadow[FRAME_LEN-1 -: CFG_BITS];

`ifdef SB_CFG_PARITY_EN
  assign w_parity_ok = ~(^r_shadow);
`else
  assign w_parity_ok = 1'b1;
`endif

  assign w_in_loaded   = (r_state == S_LOADED);
  assign w_commit_ok   = bus.prog_commit & w_in_loaded & w_parity_ok;
  assign w_commit_bad  = bus.prog_commit & ~(w_in_loaded & w_parity_ok);
  // A commit attempt in LOADED owns the cycle, even when it fails parity.
  assign w_do_shift    = bus.prog_en & ~(bus.prog_commit & w_in_loaded);
  assign w_frame_start = w_do_shift & ((r_state == S_UNCFG) | (r_state == S_ACTIVE));
  assign w_last_shift  = w_do_shift & (r_state == S_LOADING) &
                         (r_cnt == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_state      <= S_UNCFG;
      r_shadow     <= '0;
      r_active     <= '0;
      r_cnt        <= '0;
      r_cfg_active <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      if (w_do_shift) begin
        r_shadow <= {r_shadow[FRAME_LEN-2:0], bus.ccff_head};
      end

      if (w_commit_ok) begin
        r_active     <= w_shadow_cfg;
        r_cfg_active <= 1'b1;
      end

      if (w_commit_ok) begin
        r_cnt <= '0;
      end else if (w_frame_start) begin
        r_cnt <= CNT_W'(1);
      end else if (w_do_shift && (r_cnt != CNT_W'(FRAME_LEN))) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_commit_bad) begin
        r_cfg_err <= 1'b1;
      end else if (w_frame_start) begin
        r_cfg_err <= 1'b0;
      end

      if (w_commit_ok) begin
        r_state <= S_ACTIVE;
      end else if (w_frame_start) begin
        r_state <= S_LOADING;
      end else if (w_last_shift) begin
        r_state <= S_LOADED;
      end
    end
  end

  // Pads are zero-extended so every unreachable pad slot reads as 0.
  assign w_pad_ext = PAD_EXT_W'(bus.pad_in);

  genvar gi, gk;
  generate
    for (gi = 0; gi < CHAN_WIDTH; gi++) begin : g_track
      assign bus.chany_top_out[gi] = bus.chanx_right_in[(gi + 1) % CHAN_WIDTH];
      assign w_cand[gi][0]         = bus.chany_top_in[(gi + CHAN_WIDTH - 1) % CHAN_WIDTH];
      for (gk = 1; gk < NSEL; gk++) begin : g_pad
        assign w_cand[gi][gk] = w_pad_ext[gi + (gk - 1) * CHAN_WIDTH];
      end
      assign w_sel[gi]       = r_active[gi*SEL_W +: SEL_W];
      assign w_right_out[gi] = r_cfg_active & w_cand[gi][w_sel[gi]];
    end
  endgenerate

  assign bus.chanx_right_out = w_right_out;
  assign bus.ccff_tail       = r_shadow[FRAME_LEN-1];
  assign bus.cfg_ready       = w_in_loaded;
  assign bus.cfg_active      = r_cfg_active;
  assign bus.cfg_err         = r_cfg_err;
endmodule

// File: tb/tb_sb_corner_param.sv
// Scoreboard bench for sb_corner_param: expectations are queued at stimulus time and checked at output sampling.
// Build with SB_CFG_PARITY_EN defined to exercise the parity-protected frame.
module tb_sb_corner_param;
  localparam int CW = 3;
  localparam int NP = 8;
  localparam int CB = 6;
`ifdef SB_CFG_PARITY_EN
  localparam int FL = CB + 1;
`else
  localparam int FL = CB;
`endif

  logic prog_clk   = 1'b0;
  logic prog_rst_n = 1'b0;
  always #5 prog_clk = ~prog_clk;

  sb_corner_param_if #(.CHAN_WIDTH(CW), .NUM_PADS(NP)) bus ();

  sb_corner_param #(.CHAN_WIDTH(CW), .NUM_PADS(NP)) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .bus        (bus)
  );

  int          total = 0;
  int          bad   = 0;
  string       tag_q [$];
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow got=%0h exp=none", got);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_eq(t, got, e);
    end
  endtask

  function automatic logic [31:0] stat();
    return {28'd0, bus.ccff_tail, bus.cfg_ready, bus.cfg_active, bus.cfg_err};
  endfunction

  // Reference routing: sel 0 takes the neighbouring top track, sel k a pad if it exists.
  function automatic logic [2:0] route(input logic [5:0] cfg, input logic [7:0] pad, input logic [2:0] chy);
    logic [2:0] r;
    int         k;
    int         idx;
    r = '0;
    for (int i = 0; i < CW; i++) begin
      k = int'(cfg[i*2 +: 2]);
      if (k == 0) begin
        r[i] = chy[(i + CW - 1) % CW];
      end else begin
        idx  = i + (k - 1) * CW;
        r[i] = (idx < NP) ? pad[idx] : 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [FL-1:0] mk_frame(input logic [5:0] cfg);
`ifdef SB_CFG_PARITY_EN
    return {cfg, ^cfg};
`else
    return cfg;
`endif
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    bus.prog_en   = 1'b1;
    bus.ccff_head = b;
    tick();
    bus.prog_en   = 1'b0;
  endtask

  task automatic do_commit();
    bus.prog_commit = 1'b1;
    tick();
    bus.prog_commit = 1'b0;
  endtask

  task automatic route_sweep(input string tag, input logic [5:0] cfg, input int n);
    logic [7:0] p;
    logic [2:0] c;
    for (int i = 0; i < n; i++) begin
      p = 8'($urandom);
      c = 3'($urandom);
      bus.pad_in       = p;
      bus.chany_top_in = c;
      sb_push(tag, 32'(route(cfg, p, c)));
      #1;
      sb_pop(32'(bus.chanx_right_out));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]    cfg_a;
    logic [5:0]    cfg_b;
    logic [5:0]    cfg_c;
    logic [FL-1:0] fr_a;
    logic [FL-1:0] fr_b;
    logic [FL+1:0] b;
    logic [FL-1:0] sh;
    logic [31:0]   st;
    logic [2:0]    x;

    bus.prog_en        = 1'b0;
    bus.prog_commit    = 1'b0;
    bus.ccff_head      = 1'b0;
    bus.chany_top_in   = '0;
    bus.chanx_right_in = '0;
    bus.pad_in         = '0;
    prog_rst_n         = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    sb_push("reset_status", 32'h0);
    sb_push("reset_route", 32'h0);
    sb_pop(stat());
    sb_pop(32'(bus.chanx_right_out));
    prog_rst_n = 1'b1;
    #1;

    // Top channel is a fixed rotation of the right channel input.
    for (int v = 0; v < 8; v++) begin
      x = 3'(v);
      bus.chanx_right_in = x;
      sb_push("top_rotate", {29'd0, x[0], x[2], x[1]});
      #1;
      sb_pop(32'(bus.chany_top_out));
    end

    sb_push("uncfg_commit_status", 32'b0001);
    sb_push("uncfg_commit_route", 32'h0);
    do_commit();
    sb_pop(stat());
    sb_pop(32'(bus.chanx_right_out));

    cfg_a = 6'b11_10_01;
    fr_a  = mk_frame(cfg_a);
    bus.pad_in       = 8'h09;
    bus.chany_top_in = 3'b101;
    for (int n = 1; n <= FL; n++) begin
      sb_push("load_ready", 32'(n == FL));
      if (n == 1) sb_push("err_clear_on_shift", 32'h0);
      shift_bit(fr_a[FL-n]);
      st = stat();
      sb_pop(32'(st[2]));
      if (n == 1) sb_pop(32'(st[0]));
    end
    sb_push("inactive_route", 32'h0);
    sb_pop(32'(bus.chanx_right_out));

    sb_push("commit_a_status", {28'd0, fr_a[FL-1], 3'b010});
    sb_push("commit_a_route", 32'b001);
    do_commit();
    sb_pop(stat());
    sb_pop(32'(bus.chanx_right_out));
    route_sweep("route_a", cfg_a, 6);

    cfg_b = 6'b00_01_00;
    fr_b  = mk_frame(cfg_b);
    for (int n = 1; n <= 3; n++) shift_bit(fr_b[FL-n]);
    sb_push("reload_ready_active", 32'b01);
    st = stat();
    sb_pop(32'(st[2:1]));
    route_sweep("reload_keeps_route", cfg_a, 3);
    for (int n = 4; n <= FL; n++) shift_bit(fr_b[FL-n]);
    sb_push("reload_ready", 32'h1);
    st = stat();
    sb_pop(32'(st[2]));
    sb_push("commit_b_status", {28'd0, fr_b[FL-1], 3'b010});
    do_commit();
    sb_pop(stat());
    route_sweep("route_b", cfg_b, 6);

    sb_push("active_commit_status", {28'd0, fr_b[FL-1], 3'b011});
    sb_push("active_commit_route", 32'(route(cfg_b, bus.pad_in, bus.chany_top_in)));
    do_commit();
    sb_pop(stat());
    sb_pop(32'(bus.chanx_right_out));

    // Asynchronous reset in the middle of a reload, sampled before any clock edge.
    for (int n = 1; n <= 3; n++) shift_bit(fr_a[FL-n]);
    sb_push("reload_err_clear", 32'h0);
    st = stat();
    sb_pop(32'(st[0]));
    #2;
    prog_rst_n = 1'b0;
    #1;
    sb_push("midload_reset_status", 32'h0);
    sb_push("midload_reset_route", 32'h0);
    sb_pop(stat());
    sb_pop(32'(bus.chanx_right_out));
    tick();
    prog_rst_n = 1'b1;

    // Over-length frame: the extra bits push the oldest bits out of the tail.
    b = (FL+2)'($urandom);
    for (int j = 0; j < FL; j++) sh[FL-1-j] = b[2+j];
`ifdef SB_CFG_PARITY_EN
    sh[0]    = ^sh[FL-1:1];
    b[FL+1]  = sh[0];
`endif
    cfg_c = sh[FL-1 -: CB];
    for (int n = 1; n <= FL + 2; n++) begin
      sb_push("overshift_tail", 32'((n >= FL) ? b[n-FL] : 1'b0));
      sb_push("overshift_ready", 32'(n >= FL));
      shift_bit(b[n-1]);
      st = stat();
      sb_pop(32'(st[3]));
      sb_pop(32'(st[2]));
    end

    sb_push("commit_beats_shift_status", {28'd0, b[2], 3'b010});
    bus.prog_en   = 1'b1;
    bus.ccff_head = ~b[2];
    do_commit();
    bus.prog_en   = 1'b0;
    sb_pop(stat());
    route_sweep("route_c", cfg_c, 4);

`ifdef SB_CFG_PARITY_EN
    begin
      logic [5:0]    cfg_d;
      logic [FL-1:0] fr_d;
      cfg_d = 6'b01_01_10;
      fr_d  = {cfg_d, ~(^cfg_d)};
      for (int n = 1; n <= FL; n++) shift_bit(fr_d[FL-n]);
      sb_push("parity_bad_status", {28'd0, fr_d[FL-1], 3'b111});
      do_commit();
      sb_pop(stat());
      route_sweep("parity_keeps_route", cfg_c, 4);
    end
`endif

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
